// File: rtl/read_req_arbiter.sv
// read_req_arbiter: shares one AXI AR channel among three read requesters with priority, starvation guard and per-ID credits.
module read_req_arbiter #(
  parameter int MAX_OUTST    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   req_valid,
  input  logic [191:0] req_addr,
  output logic [2:0]   req_ready,
  output logic [15:0]  arid_m,
  output logic [63:0]  araddr_m,
  output logic [7:0]   arlen_m,
  output logic [2:0]   arsize_m,
  output logic         arvalid_m,
  input  logic         arready_m,
  input  logic [15:0]  rid_m,
  input  logic [1:0]   rresp_m,
  input  logic         rlast_m,
  input  logic         rvalid_m,
  output logic         rready_m,
  output logic [2:0]   rvalid_o,
  output logic [11:0]  outst_o,
  output logic         busy_o,
  output logic         err_o
);
  localparam int SW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [3:0] MAX_C = 4'(MAX_OUTST);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);
  logic [2:0][3:0] outst, outst_nxt;
  logic [SW-1:0] starve_cnt;
  logic rr, slot_free, pick1, g2, rid_ok, dec, underflow;
  logic [2:0] elig, dec_v;
  logic [1:0] gid;
  logic [63:0] gaddr;
  assign arlen_m   = 8'd0;
  assign arsize_m  = 3'b110;
  assign rready_m  = 1'b1;
  assign outst_o   = outst;
  assign busy_o    = arvalid_m | (|outst);
  assign slot_free = !arvalid_m | arready_m;
  assign rid_ok    = rid_m < 16'd3;
  assign dec       = rvalid_m & rlast_m & rid_ok;
  assign rvalid_o  = {rvalid_m & (rid_m == 16'd2), rvalid_m & (rid_m == 16'd1), rvalid_m & (rid_m == 16'd0)};
  always_comb begin
    for (int i = 0; i < 3; i++) elig[i] = req_valid[i] & (outst[i] < MAX_C) & slot_free;
    g2 = elig[2] & !((starve_cnt == STARVE_C) & (elig[0] | elig[1]));
    pick1 = elig[1] & (!elig[0] | !rr);
    req_ready = g2 ? 3'b100 : pick1 ? 3'b010 : {2'b00, elig[0]};
    gid = g2 ? 2'd2 : pick1 ? 2'd1 : 2'd0;
    gaddr = g2 ? req_addr[191:128] : pick1 ? req_addr[127:64] : req_addr[63:0];
  end
  // A same-cycle accept and rlast on one ID cancel; an unmatched rlast on an empty count holds at 0 and flags.
  always_comb begin
    underflow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dec_v[i] = dec & (rid_m[1:0] == i[1:0]);
      outst_nxt[i] = (req_ready[i] & !dec_v[i]) ? outst[i] + 4'd1 :
                     (dec_v[i] & !req_ready[i] & (outst[i] != 4'd0)) ? outst[i] - 4'd1 : outst[i];
      underflow = underflow | (dec_v[i] & !req_ready[i] & (outst[i] == 4'd0));
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      arvalid_m  <= 1'b0;
      arid_m     <= '0;
      araddr_m   <= '0;
      outst      <= '0;
      starve_cnt <= '0;
      rr         <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      if (|req_ready) begin
        arvalid_m <= 1'b1;
        arid_m    <= {14'd0, gid};
        araddr_m  <= {gaddr[63:6], 6'b0};
      end else if (arready_m) arvalid_m <= 1'b0;
      outst      <= outst_nxt;
      starve_cnt <= (req_ready[0] | req_ready[1]) ? '0 :
                    (req_ready[2] & (|req_valid[1:0]) & (starve_cnt != STARVE_C)) ? starve_cnt + SW'(1) : starve_cnt;
      rr         <= req_ready[0] ? 1'b0 : req_ready[1] ? 1'b1 : rr;
      err_o      <= err_o | (rvalid_m & ((rresp_m != 2'b00) | !rid_ok)) | underflow;
    end
  end
endmodule

// File: tb/tb_read_req_arbiter.sv
// tb_read_req_arbiter: directed self-checking bench for read_req_arbiter.
module tb_read_req_arbiter;
  logic clk = 0, rst;
  logic [2:0] req_valid, req_ready, rvalid_o;
  logic [191:0] req_addr;
  logic [15:0] arid_m, rid_m;
  logic [63:0] araddr_m;
  logic [7:0] arlen_m;
  logic [2:0] arsize_m;
  logic arvalid_m, arready_m, rlast_m, rvalid_m, rready_m, busy_o, err_o;
  logic [1:0] rresp_m;
  logic [11:0] outst_o;
  int n_cmp = 0, n_err = 0, acc;
  int exp_rr [4] = '{0, 1, 0, 1};
  int exp_pr [12] = '{2, 2, 2, 0, 2, 2, 2, 1, 2, 2, 2, 0};

  read_req_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
    .arvalid_m(arvalid_m), .arready_m(arready_m), .rid_m(rid_m), .rresp_m(rresp_m),
    .rlast_m(rlast_m), .rvalid_m(rvalid_m), .rready_m(rready_m), .rvalid_o(rvalid_o),
    .outst_o(outst_o), .busy_o(busy_o), .err_o(err_o));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [15:0] id, input logic [1:0] resp);
    rvalid_m = 1; rlast_m = 1; rid_m = id; rresp_m = resp;
  endtask

  task automatic no_beat;
    rvalid_m = 0; rlast_m = 0; rid_m = 0; rresp_m = 0;
  endtask

  initial begin
    rst = 1; req_valid = 0; req_addr = 0; arready_m = 1; no_beat;
    tick;
    chk("const_rready", {63'd0, rready_m}, 1);
    chk("const_arlen", {56'd0, arlen_m}, 0);
    chk("const_arsize", {61'd0, arsize_m}, 64'd6);
    tick;
    rst = 0;
    chk("rst_arvalid", {63'd0, arvalid_m}, 0);
    chk("rst_outst", {52'd0, outst_o}, 0);
    chk("rst_err", {63'd0, err_o}, 0);
    chk("rst_busy", {63'd0, busy_o}, 0);
    // single request then back-to-back up to the credit limit
    req_valid = 3'b001; req_addr[63:0] = 64'h1047;
    #1 chk("single_ready", {61'd0, req_ready}, 3'b001);
    tick;
    chk("single_arvalid", {63'd0, arvalid_m}, 1);
    chk("single_araddr", araddr_m, 64'h1040);
    chk("single_arid", {48'd0, arid_m}, 0);
    chk("single_outst0", {60'd0, outst_o[3:0]}, 1);
    chk("single_busy", {63'd0, busy_o}, 1);
    acc = 1;
    for (int k = 0; k < 6; k++) begin
      if (req_ready[0]) acc++;
      tick;
    end
    chk("b2b_ar_count", 64'(acc), 4);
    chk("b2b_outst0", {60'd0, outst_o[3:0]}, 4);
    chk("b2b_ready_blocked", {61'd0, req_ready}, 0);
    beat(0, 0);
    #1 chk("ready_ignores_rvalid", {61'd0, req_ready}, 0);
    chk("rvalid_o_id0", {61'd0, rvalid_o}, 3'b001);
    tick;
    no_beat;
    chk("credit_back_outst0", {60'd0, outst_o[3:0]}, 3);
    chk("credit_back_ready", {61'd0, req_ready}, 3'b001);
    req_valid = 0;
    for (int k = 0; k < 3; k++) begin beat(0, 0); tick; end
    no_beat;
    chk("drain_outst0", {60'd0, outst_o[3:0]}, 0);
    chk("drain_arvalid", {63'd0, arvalid_m}, 0);
    // backpressure
    arready_m = 0; req_valid = 3'b001; req_addr[63:0] = 64'h2085;
    tick;
    req_valid = 3'b111; req_addr[127:64] = 64'h5555; req_addr[191:128] = 64'h7777;
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_ready", {61'd0, req_ready}, 0);
      tick;
      chk("bp_arvalid", {63'd0, arvalid_m}, 1);
      chk("bp_araddr", araddr_m, 64'h2080);
      chk("bp_arid", {48'd0, arid_m}, 0);
    end
    arready_m = 1; req_valid = 0;
    tick;
    chk("bp_release", {63'd0, arvalid_m}, 0);
    beat(0, 0); tick; no_beat;
    chk("bp_drain", {52'd0, outst_o}, 0);
    // lone ID-1 grant so ID 1 is the last round-robin winner
    req_valid = 3'b010; req_addr[127:64] = 64'h30ff;
    tick;
    req_valid = 0;
    chk("id1_arid", {48'd0, arid_m}, 1);
    chk("id1_araddr", araddr_m, 64'h30c0);
    beat(1, 0); tick; no_beat;
    chk("id1_drain", {52'd0, outst_o}, 0);
    // round-robin between ID 0 and ID 1, responses returned as ARs handshake
    req_valid = 3'b011;
    for (int k = 0; k < 4; k++) begin
      if (arvalid_m) beat(arid_m, 0); else no_beat;
      tick;
      chk("rr_grant", {48'd0, arid_m}, 64'(exp_rr[k]));
    end
    req_valid = 3'b111;
    for (int k = 0; k < 12; k++) begin
      beat(arid_m, 0);
      tick;
      chk("prio_grant", {48'd0, arid_m}, 64'(exp_pr[k]));
    end
    req_valid = 0; beat(arid_m, 0); tick; no_beat;
    chk("prio_drain", {52'd0, outst_o}, 0);
    chk("prio_no_err", {63'd0, err_o}, 0);
    // simultaneous accept and decrement on ID 1
    req_valid = 3'b010;
    tick; tick;
    chk("sim_pre_outst1", {60'd0, outst_o[7:4]}, 2);
    beat(1, 0);
    #1 chk("sim_ready", {61'd0, req_ready}, 3'b010);
    tick;
    req_valid = 0; no_beat;
    chk("sim_outst1", {60'd0, outst_o[7:4]}, 2);
    // error response still returns the credit
    beat(1, 2'b10); tick; no_beat;
    chk("rresp_err", {63'd0, err_o}, 1);
    chk("rresp_outst1", {60'd0, outst_o[7:4]}, 1);
    // reset mid-burst
    req_valid = 3'b001;
    tick; tick; tick;
    req_valid = 0;
    chk("mid_outst0", {60'd0, outst_o[3:0]}, 3);
    chk("mid_arvalid", {63'd0, arvalid_m}, 1);
    rst = 1; tick; rst = 0;
    chk("mid_rst_arvalid", {63'd0, arvalid_m}, 0);
    chk("mid_rst_outst", {52'd0, outst_o}, 0);
    chk("mid_rst_err", {63'd0, err_o}, 0);
    chk("mid_rst_araddr", araddr_m, 0);
    chk("mid_rst_arid", {48'd0, arid_m}, 0);
    // out-of-range ID flags without touching counts
    req_valid = 3'b010; tick; req_valid = 0;
    beat(5, 0);
    #1 chk("rid5_rvalid_o", {61'd0, rvalid_o}, 0);
    tick; no_beat;
    chk("rid5_err", {63'd0, err_o}, 1);
    chk("rid5_outst1", {60'd0, outst_o[7:4]}, 1);
    // stray beat after reset hits the no-wrap rule
    rst = 1; tick; rst = 0;
    chk("stray_pre_err", {63'd0, err_o}, 0);
    beat(0, 0); tick; no_beat;
    chk("stray_err", {63'd0, err_o}, 1);
    chk("stray_outst0", {60'd0, outst_o[3:0]}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/read_req_arbiter.md
# read_req_arbiter

Shares the PageRank engine's single AXI read-address channel among three requesters: vertex fetch (ID 0), in-edge fetch (ID 1) and PageRank-value fetch (ID 2). Applies priority with a starvation guard and enforces a per-requester outstanding-read credit limit so that no read buffer is overrun. Demultiplexes the R channel back to the requesters by ID. Sits between the PageRank sequencing FSM/read buffers and the memory AXI master port.

## Interface
- MAX_OUTST, default 4: maximum outstanding reads per requester (1–15).
- STARVE_LIMIT, default 3: consecutive ID-2 grants allowed while ID 0 or ID 1 is waiting.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  3  per-requester request valid; bit i corresponds to ID i.
- req_addr  in  3×64  per-requester byte address, flattened; requester i occupies bits [64i+63:64i].
- req_ready  out  3  per-requester accept, combinational.
- arid_m  out  16  registered read ID.
- araddr_m  out  64  registered read address; bits [5:0] are forced to 0.
- arlen_m  out  8  constant 0.
- arsize_m  out  3  constant 3'b110 (64 bytes).
- arvalid_m  out  1  registered.
- arready_m  in  1  slave accept.
- rid_m  in  16  response ID.
- rresp_m  in  2  response code.
- rlast_m  in  1  last beat of the response.
- rvalid_m  in  1  response valid.
- rready_m  out  1  constant 1.
- rvalid_o  out  3  rvalid_o[i] = rvalid_m & (rid_m == i).
- outst_o  out  3×4  per-requester outstanding-read count.
- busy_o  out  1  arvalid_m, or any outstanding-read count nonzero.
- err_o  out  1  sticky error flag; cleared only by rst.

## Operation
- **AR slot:** a single output register. The slot is free when !arvalid_m | arready_m.
- **Eligibility:** requester i is eligible when req_valid[i] is set, outst[i] < MAX_OUTST, and the slot is free.
- **Grant priority:**
  - ID 2 wins, unless starve_cnt == STARVE_LIMIT and ID 0 or ID 1 is eligible.
  - Otherwise ID 0 and ID 1 share by round-robin using a 1-bit last-grant pointer `rr`. The non-last requester wins ties. `rr` updates only on an ID-0 or ID-1 grant.
- **starve_cnt** (width $clog2(STARVE_LIMIT+1)):
  - Increments on an ID-2 grant while ID 0 or ID 1 has req_valid set.
  - Clears on an ID-0 or ID-1 grant.
  - Holds when nobody waits.
- **req_ready:** only the granted requester's bit is set; at most one bit is high per cycle.
- **Accept (req_valid[i] & req_ready[i]):**
  - Loads araddr_m = {req_addr_i[63:6], 6'b0} and arid_m = i.
  - Sets arvalid_m = 1.
  - Increments outst[i].
- **AR handshake:** on arvalid_m & arready_m with no new accept, arvalid_m clears. With a new accept in the same cycle, the register reloads and arvalid_m stays 1 (back-to-back operation).
- **R channel:**
  - A beat with rvalid_m & rlast_m & (rid_m < 3) decrements outst[rid_m].
  - A simultaneous accept and decrement on the same ID leaves the count unchanged.
- **err_o sets** when:
  - rvalid_m arrives with rresp_m != 0 (the counter still decrements);
  - rvalid_m arrives with rid_m ≥ 3 (no counter changes);
  - a decrement would take a count below 0 (the count holds at 0, no wrap).
- **Reset:** arvalid_m, arid_m, araddr_m, outst[*], starve_cnt, rr and err_o all reset to 0.
  - Responses that arrive after reset for pre-reset requests are handled by the no-wrap rule: they flag err_o.

## Timing
- Request-to-arvalid_m latency is 1 cycle: accept in cycle N gives arvalid_m = 1 in cycle N+1.
- araddr_m and arid_m are stable while arvalid_m & !arready_m.
- Sustained throughput is 1 AR per cycle when arready_m is held at 1.
- req_ready depends combinationally on req_valid, outst, arvalid_m and arready_m. It does not depend on rvalid_m in the same cycle; decrements take effect next cycle.
- outst_o reflects a change 1 cycle after the causing event.
- rvalid_o is purely combinational from rvalid_m and rid_m.
- rready_m = 1, arlen_m = 0 and arsize_m = 3'b110 hold at all times, including during reset.

## Test plan
- **Single request, then back-to-back:**
  - Stimulus: req_valid = 3'b001, addr 0x1047, arready_m = 1.
  - Required: arvalid_m in cycle N+1 with araddr_m = 0x1040 and arid_m = 0; outst_o[0] = 1.
  - Stimulus: then 4 more back-to-back requests.
  - Required: exactly 4 ARs total issue (MAX_OUTST = 4); req_ready[0] stays 0 until an rlast beat with rid = 0.
- **Backpressure:**
  - Stimulus: arready_m = 0 for 5 cycles.
  - Required: arvalid_m, araddr_m and arid_m are held constant; no req_ready is asserted.
- **Priority and starvation guard:**
  - Stimulus: all three requesters continuously valid, arready_m = 1, credits replenished.
  - Required: grant sequence 2,2,2,0,2,2,2,1,2,2,2,0, …
- **Round-robin without ID 2:**
  - Stimulus: ID 0 and ID 1 continuously valid.
  - Required: grants alternate 0,1,0,1.
- **Simultaneous accept and decrement:**
  - Stimulus: with outst[1] = 2, an ID-1 accept and an rlast beat with rid = 1 occur in the same cycle.
  - Required: outst[1] stays at 2.
- **Error cases and reset:**
  - rresp_m = 2'b10 sets err_o, and the counter still decrements.
  - rid = 5 sets err_o with no counter change.
  - rst mid-burst (arvalid_m = 1, outst[0] = 3) clears all registered state next cycle. A later stray rid = 0 beat sets err_o and outst[0] stays 0.
